// File: rtl/rf68000_nic_pkg.sv
// Shared types and helpers for the node network interface Wishbone initiator.
package rf68000_nic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CYC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Upper address half that selects the node window for a given node id.
    function automatic logic [15:0] NODE_HI(input logic [7:0] id);
        return {8'hFF, id};
    endfunction

endpackage

// File: rtl/rf68000_nic_initiator.sv
// Single-word Wishbone initiator for the node NIC port: one classic bus cycle
// per request, bounded by a timeout, with a held response until consumed.
module rf68000_nic_initiator
    import rf68000_nic_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TAGW    = 8
) (
    input  logic            rst_i,
    input  logic            clk_i,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [3:0]      req_sel,
    input  logic [31:0]     req_adr,
    input  logic [31:0]     req_dat,
    input  logic [TAGW-1:0] req_tag,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_dat,
    output logic [TAGW-1:0] resp_tag,
    output logic            resp_err,
    output logic [15:0]     err_cnt,
    output logic            nic_cyc,
    output logic            nic_stb,
    output logic            nic_we,
    output logic [3:0]      nic_sel,
    output logic [31:0]     nic_adr,
    output logic [31:0]     nic_dato,
    input  logic            nic_ack,
    input  logic [31:0]     nic_dati
);

    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [15:0]     tmr_q, tmr_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_dat_q, resp_dat_d;
    logic [TAGW-1:0] resp_tag_q, resp_tag_d;
    logic            resp_err_q, resp_err_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dato_q, dato_d;
    logic [TAGW-1:0] tag_q, tag_d;

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_dat_d   = resp_dat_q;
        resp_tag_d   = resp_tag_q;
        resp_err_d   = resp_err_q;
        err_cnt_d    = err_cnt_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dato_d       = dato_q;
        tag_d        = tag_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = TRUE;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    sel_d       = req_sel;
                    adr_d       = req_adr;
                    dato_d      = req_dat;
                    tag_d       = req_tag;
                    cyc_d       = TRUE;
                    req_ready_d = FALSE;
                    tmr_d       = '0;
                    state_d     = ST_CYC;
                end
            end
            ST_CYC: begin
                tmr_d = tmr_q + 16'd1;
                // An ack in the first bus cycle is a leftover from the arbiter's previous owner.
                if (nic_ack && (tmr_q != 16'd0)) begin
                    resp_dat_d   = we_q ? 32'd0 : nic_dati;
                    resp_err_d   = FALSE;
                    resp_valid_d = TRUE;
                    resp_tag_d   = tag_q;
                    cyc_d        = FALSE;
                    we_d         = FALSE;
                    sel_d        = '0;
                    state_d      = ST_RESP;
                end else if (tmr_q == TMR_LAST) begin
                    resp_dat_d   = '0;
                    resp_err_d   = TRUE;
                    resp_valid_d = TRUE;
                    resp_tag_d   = tag_q;
                    cyc_d        = FALSE;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = FALSE;
                    req_ready_d  = TRUE;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cyc_d        = FALSE;
                req_ready_d  = FALSE;
                resp_valid_d = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            req_ready_q  <= FALSE;
            resp_valid_q <= FALSE;
            resp_dat_q   <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= FALSE;
            err_cnt_q    <= '0;
            cyc_q        <= FALSE;
            we_q         <= FALSE;
            sel_q        <= '0;
            adr_q        <= '0;
            dato_q       <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_dat_q   <= resp_dat_d;
            resp_tag_q   <= resp_tag_d;
            resp_err_q   <= resp_err_d;
            err_cnt_q    <= err_cnt_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dato_q       <= dato_d;
            tag_q        <= tag_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_dat   = resp_dat_q;
    assign resp_tag   = resp_tag_q;
    assign resp_err   = resp_err_q;
    assign err_cnt    = err_cnt_q;
    assign nic_cyc    = cyc_q;
    assign nic_stb    = cyc_q;
    assign nic_we     = we_q;
    assign nic_sel    = sel_q;
    assign nic_adr    = adr_q;
    assign nic_dato   = dato_q;

endmodule

// File: tb/tb_rf68000_nic_initiator.sv
// Bench for rf68000_nic_initiator: scripted requests, a behavioural Wishbone
// responder, and an in-order response scoreboard.
module tb_rf68000_nic_initiator;

    localparam int TO = 8;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid, req_ready, req_we;
    logic [3:0]    req_sel;
    logic [31:0]   req_adr, req_dat;
    logic [TW-1:0] req_tag;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_dat;
    logic [TW-1:0] resp_tag;
    logic [15:0]   err_cnt;
    logic          nic_cyc, nic_stb, nic_we, nic_ack;
    logic [3:0]    nic_sel;
    logic [31:0]   nic_adr, nic_dato, nic_dati;

    always #5 clk = ~clk;

    rf68000_nic_initiator #(.TIMEOUT(TO), .TAGW(TW)) dut (
        .rst_i(rst_i), .clk_i(clk),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dat(resp_dat),
        .resp_tag(resp_tag), .resp_err(resp_err), .err_cnt(err_cnt),
        .nic_cyc(nic_cyc), .nic_stb(nic_stb), .nic_we(nic_we), .nic_sel(nic_sel),
        .nic_adr(nic_adr), .nic_dato(nic_dato), .nic_ack(nic_ack), .nic_dati(nic_dati)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus environment: memory with a fixed fill pattern for unwritten words.
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    logic rsp_ack = 1'b0;
    logic inj_ack = 1'b0;
    logic silent  = 1'b0;
    int   ack_dly = 2;
    int   hi_cnt = 0, lo_cnt = 0, last_gap = 0, last_hi = 0;
    logic cyc_prev = 1'b0;
    logic        seen_we = 1'b0;
    logic [31:0] seen_adr = '0, seen_dato = '0;

    assign nic_ack = rsp_ack | inj_ack;

    initial nic_dati = 32'hBAD0_BAD0;

    // Responder: acks once cyc has been high for ack_dly+1 cycles.
    always @(posedge clk) begin
        #1;
        if (nic_cyc) begin
            if (!cyc_prev) last_gap = lo_cnt;
            hi_cnt++;
            lo_cnt = 0;
        end else begin
            if (cyc_prev) last_hi = hi_cnt;
            hi_cnt = 0;
            lo_cnt++;
        end
        cyc_prev = nic_cyc;
        rsp_ack  = nic_cyc && !silent && (hi_cnt == ack_dly + 1);
        nic_dati = 32'hBAD0_BAD0;
        if (rsp_ack) begin
            seen_we   = nic_we;
            seen_adr  = nic_adr;
            seen_dato = nic_dato;
            if (nic_we) bus_mem[nic_adr] = nic_dato;
            else nic_dati = bus_mem.exists(nic_adr) ? bus_mem[nic_adr] : fill(nic_adr);
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   dat;
        logic          err;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_i && nic_cyc) chk("stb_eq_cyc", 32'(nic_stb), 32'(nic_cyc));
        if (!rst_i && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_tag", 32'(resp_tag), 32'(e.tag));
                chk("resp_dat", resp_dat, e.dat);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [TW-1:0] tag, input logic exp_err);
        exp_t e;
        req_we    = we;
        req_sel   = 4'hF;
        req_adr   = adr;
        req_dat   = dat;
        req_tag   = tag;
        req_valid = 1'b1;
        e.tag = tag;
        e.err = exp_err;
        e.dat = (exp_err || we) ? 32'd0 : ref_rd(adr);
        if (we && !exp_err) ref_mem[adr] = dat;
        sb.push_back(e);
    endtask

    task automatic wait_accept();
        logic got;
        int n = 0;
        do begin
            got = req_ready;
            tick();
            n++;
        end while (!got && n < 50);
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp_done();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("resp_wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   hd;
        logic [TW-1:0] ht;
        logic          he;
        int            n;
        rst_i = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = '0;
        req_adr = '0; req_dat = '0; req_tag = '0; resp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cyc", 32'(nic_cyc), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_adr", nic_adr, 32'd0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // write then read back
        start_req(1'b1, 32'hFFF0_0010, 32'hDEAD_BEEF, 8'h5A, 1'b0);
        wait_accept();
        wait_resp_done();
        chk("wr_we", 32'(seen_we), 32'd1);
        chk("wr_adr", seen_adr, 32'hFFF0_0010);
        chk("wr_dato", seen_dato, 32'hDEAD_BEEF);
        start_req(1'b0, 32'hFFF0_0010, 32'd0, 8'h5B, 1'b0);
        wait_accept();
        wait_resp_done();
        chk("rd_we", 32'(seen_we), 32'd0);

        // ack-to-response latency
        ack_dly = 4;
        start_req(1'b0, 32'hFFF0_0020, 32'd0, 8'h11, 1'b0);
        wait_accept();
        n = 0;
        while (!nic_ack && n < 20) begin tick(); n++; end
        chk("ack_after_cyc", 32'(n), 32'd4);
        tick();
        chk("lat_resp_valid", 32'(resp_valid), 32'd1);
        chk("lat_cyc_low", 32'(nic_cyc), 32'd0);
        chk("lat_dat", resp_dat, fill(32'hFFF0_0020));
        wait_resp_done();

        // timeout with silent responder, then stray ack
        silent = 1'b1;
        start_req(1'b0, 32'hFFF0_0030, 32'd0, 8'h22, 1'b1);
        wait_accept();
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        chk("to_latency", 32'(n), 32'(TO));
        chk("to_cyc_len", 32'(last_hi), 32'(TO));
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        wait_resp_done();
        inj_ack = 1'b1;
        tick(); tick();
        inj_ack = 1'b0;
        tick();
        chk("stray_no_resp", 32'(resp_valid), 32'd0);
        chk("stray_no_cyc", 32'(nic_cyc), 32'd0);
        chk("stray_err_cnt", 32'(err_cnt), 32'd1);
        silent = 1'b0;

        // consumer back-pressure
        ack_dly = 1;
        resp_ready = 1'b0;
        start_req(1'b0, 32'hFFF0_0040, 32'd0, 8'h33, 1'b0);
        wait_accept();
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        hd = resp_dat; ht = resp_tag; he = resp_err;
        start_req(1'b1, 32'hFFF0_0044, 32'h1234_5678, 8'h34, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_dat", resp_dat, hd);
            chk("hold_tag", 32'(resp_tag), 32'(ht));
            chk("hold_err", 32'(resp_err), 32'(he));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_cyc", 32'(nic_cyc), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("rel_ready", 32'(req_ready), 32'd1);
        tick();
        chk("rel_accept", 32'(nic_cyc), 32'd1);
        req_valid = 1'b0;
        wait_resp_done();

        // back-to-back with stale ack on the first cycle of the second
        ack_dly = 2;
        start_req(1'b0, 32'hFFF0_0050, 32'd0, 8'h44, 1'b0);
        wait_accept();
        start_req(1'b0, 32'hFFF0_0054, 32'd0, 8'h45, 1'b0);
        wait_accept();
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        chk("stale_no_resp", 32'(resp_valid), 32'd0);
        chk("stale_cyc_high", 32'(nic_cyc), 32'd1);
        chk("cyc_gap", 32'(last_gap >= 2), 32'd1);
        wait_resp_done();

        // reset during a bus cycle
        silent = 1'b1;
        start_req(1'b0, 32'hFFF0_0060, 32'd0, 8'h55, 1'b1);
        wait_accept();
        tick();
        rst_i = 1'b1;
        void'(sb.pop_back());
        tick();
        chk("rst_mid_cyc", 32'(nic_cyc), 32'd0);
        chk("rst_mid_stb", 32'(nic_stb), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
        chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        silent = 1'b0;
        repeat (TO + 4) tick();
        chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_mid_idle_cyc", 32'(nic_cyc), 32'd0);

        // normal traffic after reset
        start_req(1'b1, 32'hFFF0_0070, 32'hCAFE_F00D, 8'h66, 1'b0);
        wait_accept();
        start_req(1'b0, 32'hFFF0_0070, 32'd0, 8'h67, 1'b0);
        wait_accept();
        wait_resp_done();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rf68000_nic_initiator.md
# rf68000_nic_initiator

Wishbone initiator for the node network interface. It accepts single-word read/write commands on a valid/ready request port, runs one classic Wishbone cycle per command on the node's `nic_*` bus, and returns data, tag and error on a valid/ready response port. It sits between the ring-packet decoder and the node arbiter's NIC port, and is the bus master that arbiter services. It bounds every cycle with a timeout and guarantees the cycle-gap behaviour the arbiter's ownership lock depends on.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles with `nic_stb` high before the cycle is abandoned. Legal range is 2..65535.
- `TAGW`, default 8: width of the request/response tag.

Ports. The block uses one clock, `clk_i`. Reset `rst_i` is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `clk_i` in 1: clock; all logic is on the rising edge.
- `req_valid` in 1: a command is presented.
- `req_ready` out 1: the block can accept a command. Registered.
- `req_we` in 1: 1 = write, 0 = read.
- `req_sel` in 4: byte lane selects.
- `req_adr` in 32: byte address.
- `req_dat` in 32: write data.
- `req_tag` in TAGW: opaque tag, echoed on the response.
- `resp_valid` out 1: a response is held.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_dat` out 32: read data. 0 for writes and for timeouts.
- `resp_tag` out TAGW: echoed tag.
- `resp_err` out 1: 1 = the cycle timed out.
- `err_cnt` out 16: saturating count of timeouts.
- `nic_cyc`, `nic_stb` out 1 each: Wishbone cycle and strobe, always equal.
- `nic_we` out 1, `nic_sel` out 4, `nic_adr` out 32, `nic_dato` out 32: latched command fields.
- `nic_ack` in 1: acknowledge from the arbiter.
- `nic_dati` in 32: read data from the arbiter.

## Operation
- States: `ST_IDLE`, `ST_CYC`, `ST_RESP`.
- ST_IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`: latch we/sel/adr/dat/tag into the `nic_*` and tag registers, set `nic_cyc`=`nic_stb`=1, clear `req_ready`, clear `tmr`, go to ST_CYC.
- ST_CYC:
  - `tmr` increments every cycle.
  - `nic_ack` is honoured only when `tmr`≥1. This ignores a stale ack left over from the arbiter's previous cycle.
  - On a valid ack:
    - `resp_dat` = `nic_we` ? 0 : `nic_dati`, `resp_err`=0, `resp_valid`=1.
    - Drop `nic_cyc`/`nic_stb` and clear `nic_we`/`nic_sel`.
    - Go to ST_RESP.
  - Else, if `tmr`==TIMEOUT-1:
    - Drop `cyc`/`stb`, `resp_dat`=0, `resp_err`=1, `resp_valid`=1.
    - `err_cnt` increments, saturating at 16'hFFFF.
    - Go to ST_RESP.
  - An ack and a timeout in the same cycle: the ack wins.
- ST_RESP: hold all response outputs stable until `resp_ready`. Then clear `resp_valid`, set `req_ready`=1, go to ST_IDLE.
- An `nic_ack` outside ST_CYC (late ack after a timeout) is ignored and never produces a response.
- Addresses outside the node window FFx(id) are acked immediately with zero data by the arbiter. The block forwards that as a normal response and does not filter it.
- An undefined state goes to ST_IDLE with `cyc` low.

## Timing
- Reset values:
  - `req_ready`=0 during reset and 1 on the first cycle after it.
  - `resp_valid`=0, `resp_dat`=0, `resp_tag`=0, `resp_err`=0, `err_cnt`=0.
  - `nic_cyc`=`nic_stb`=0, `nic_we`=0, `nic_sel`=0, `nic_adr`=0, `nic_dato`=0.
  - state=ST_IDLE.
- `nic_cyc` rises the cycle after the request handshake.
- `cyc`/`stb` fall the cycle after a valid ack is sampled, so the ack-to-release latency is 1.
- `resp_valid` rises on that same edge.
- Local-RAM access through the arbiter acks about 4 cycles after `cyc` rises. Request-to-response latency is therefore about 6 cycles.
- `nic_cyc` is low for at least 2 cycles between commands (ST_RESP plus ST_IDLE). This satisfies the arbiter's release of the NIC lock on `!nic_cyc`.
- A timeout asserts `resp_valid` exactly TIMEOUT cycles after `cyc` rises.
- Reset mid-cycle drops `cyc` on the next edge. Any pending response is discarded.

## Structure
- `rf68000_nic_pkg` holds:
  - `state_t` (enum logic [1:0]);
  - TRUE/FALSE;
  - the node-window compare helper `NODE_HI(id)` = {8'hFF, id}.
- No sub-module is required. The timeout counter is a 16-bit register inline.

## Test plan
- Write: adr=FFF00010, dat=DEADBEEF, sel=F, tag=5A.
  - Required: one cycle with `nic_we`=1.
  - Response dat=0, err=0, tag=5A.
  - A following read of the same address returns DEADBEEF.
- Read with the responder acking 4 cycles after `cyc` rises.
  - Required: `resp_valid` is seen exactly 1 cycle after the ack.
  - `cyc` is low on that same cycle, and `resp_dat` equals `nic_dati`.
- Silent responder, TIMEOUT=8.
  - Required: `cyc` is high for 8 cycles, then resp err=1, dat=0, `err_cnt`=1.
  - A later stray ack is ignored.
- Hold `resp_ready`=0 for 10 cycles.
  - Required: response fields are stable, `req_ready`=0, `cyc` stays low.
  - On release, the next request is accepted within 1 cycle.
- Back-to-back requests, with `nic_ack` driven high on the first cycle of the second bus cycle (stale ack).
  - Required: the stale ack is ignored.
  - `cyc` has ≥2 low cycles between the two transactions.
- Assert `rst_i` while in ST_CYC.
  - Required: `cyc`/`stb` are 0 the next cycle.
  - No response is issued, and `req_ready`=1 after reset deasserts.
